// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: FSM states and the
// button bit positions within the keycode byte.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bit_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/controller_reader.sv
// NES controller poller: strobes the pad latch, clocks out eight serial bits
// and publishes them active-high on keycodes, on demand or periodically.
module controller_reader
  import nes_pkg::*;
#(
  parameter int HALF_CYCLES  = 300,
  parameter int LATCH_CYCLES = 600,
  parameter int POLL_PERIOD  = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] keycodes,
  output logic       keycodes_valid,
  output logic       busy
);

  localparam int TIMER_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW        = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;
  localparam int PW        = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [PW-1:0]   period_cnt_reg;
  logic [2:0]      bit_idx_reg;
  logic [7:0]      shift_reg;
  logic [7:0]      keycodes_reg;
  logic            keycodes_valid_reg;
  logic            data_sync;
  logic            timer_done;
  logic            expire;
  logic            accept;
  logic            sample_en;
  logic            load_keys;

  bit_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_sync)
  );

  // Free-running poll timer; parked at zero whenever auto polling is off.
  always_ff @(posedge clk) begin
    if (reset || !auto_en || expire) begin
      period_cnt_reg <= '0;
    end else begin
      period_cnt_reg <= period_cnt_reg + PW'(1);
    end
  end

  assign expire     = auto_en && (period_cnt_reg == PW'(POLL_PERIOD - 1));
  assign timer_done = (timer_reg == '0);
  // The DONE->IDLE cycle still counts as busy, so triggers there are dropped.
  assign accept     = (state_reg == IDLE) && !keycodes_valid_reg && (start || expire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = LATCH;
      LATCH:   if (timer_done) state_next = SETTLE;
      SETTLE:  if (timer_done) state_next = CLK_HI;
      CLK_HI:  if (timer_done) state_next = CLK_LO;
      CLK_LO:  if (timer_done) state_next = (bit_idx_reg == 3'(BTN_RIGHT)) ? DONE : CLK_HI;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    sample_en = 1'b0;
    load_keys = 1'b0;
    case (state_reg)
      LATCH:   pad_latch = 1'b1;
      SETTLE:  sample_en = timer_done;
      CLK_HI:  pad_clk   = 1'b1;
      CLK_LO:  sample_en = timer_done;
      DONE:    load_keys = 1'b1;
      default: ;
    endcase
  end

  // Each state's dwell time is loaded on entry and counted down to zero.
  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg) begin
      case (state_next)
        LATCH:                  timer_next = TW'(LATCH_CYCLES - 1);
        SETTLE, CLK_HI, CLK_LO: timer_next = TW'(HALF_CYCLES - 1);
        default:                timer_next = '0;
      endcase
    end else if (!timer_done) begin
      timer_next = timer_reg - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_reg          <= '0;
      bit_idx_reg        <= '0;
      shift_reg          <= '0;
      keycodes_reg       <= '0;
      keycodes_valid_reg <= 1'b0;
    end else begin
      timer_reg          <= timer_next;
      keycodes_valid_reg <= load_keys;
      if (accept) begin
        bit_idx_reg <= '0;
      end else if (sample_en) begin
        shift_reg[bit_idx_reg] <= data_sync;
        bit_idx_reg            <= bit_idx_reg + 3'd1;
      end
      if (load_keys) begin
        keycodes_reg <= ~shift_reg;
      end
    end
  end

  assign keycodes       = keycodes_reg;
  assign keycodes_valid = keycodes_valid_reg;
  assign busy           = (state_reg != IDLE) || keycodes_valid_reg;

endmodule

// File: tb/tb_controller_reader.sv
// Directed bench for controller_reader with a behavioural NES pad model.
module tb_controller_reader;

  localparam int HC = 4;
  localparam int LC = 8;
  localparam int PP = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       auto_en = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] keycodes;
  logic       keycodes_valid;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  controller_reader #(
    .HALF_CYCLES  (HC),
    .LATCH_CYCLES (LC),
    .POLL_PERIOD  (PP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .auto_en        (auto_en),
    .pad_data       (pad_data),
    .pad_latch      (pad_latch),
    .pad_clk        (pad_clk),
    .keycodes       (keycodes),
    .keycodes_valid (keycodes_valid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Pad: latch loads the active-low button word, each pad_clk rise shifts.
  // pad_mode 0 = serial model, 1 = stuck high (unplugged), 2 = stuck low.
  logic [7:0] pad_word = 8'hFF;
  logic [7:0] pad_sr = 8'hFF;
  logic [1:0] pad_mode = 2'd0;

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_sr <= pad_word;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end

  assign pad_data = (pad_mode == 2'd0) ? pad_sr[0] : (pad_mode == 2'd1);

  int   valid_cnt, latch_cyc, clk_pulses, hi_bad, gap_bad, overlap, hi_run, lo_run;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    valid_cnt += int'(keycodes_valid);
    latch_cyc += int'(pad_latch);
    overlap   += int'(pad_latch && pad_clk);
    if (pad_clk) begin
      if (!prev_clk) begin
        if (clk_pulses > 0 && lo_run != HC) gap_bad++;
        clk_pulses++;
        hi_run = 0;
      end
      hi_run++;
    end else begin
      if (prev_clk) begin
        if (hi_run != HC) hi_bad++;
        lo_run = 0;
      end
      lo_run++;
    end
    prev_clk = pad_clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    valid_cnt = 0; latch_cyc = 0; clk_pulses = 0; hi_bad = 0;
    gap_bad = 0; overlap = 0; hi_run = 0; lo_run = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    $display("check %-16s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!keycodes_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  // One start-triggered poll; second_at > 0 fires an extra start mid-poll.
  task automatic run_poll(input logic [7:0] exp, input int second_at, input string tag);
    int         n;
    int         busy_lo;
    logic [7:0] old;
    old = keycodes;
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    busy_lo = 0;
    while (!keycodes_valid && n < 200) begin
      if (!busy) busy_lo++;
      if (n == 30) check({tag, "_hold"}, 32'(keycodes), 32'(old));
      start = (second_at > 0) && (n == second_at);
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, LC + 15 * HC + 1);
    check({tag, "_keys"}, 32'(keycodes), 32'(exp));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    check({tag, "_busy_lo"}, busy_lo, 0);
    check({tag, "_latch_cyc"}, latch_cyc, LC);
    check({tag, "_clk_pulses"}, clk_pulses, 7);
    check({tag, "_clk_shape"}, hi_bad + gap_bad, 0);
    check({tag, "_overlap"}, overlap, 0);
    tick();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_valid_cnt"}, valid_cnt, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_stats();
    repeat (3) tick();
    check("rst_latch", 32'(pad_latch), 32'd0);
    check("rst_clk", 32'(pad_clk), 32'd0);
    check("rst_keys", 32'(keycodes), 32'd0);
    check("rst_valid", 32'(keycodes_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    // A + Select pressed (active-low 1111_1010).
    pad_word = 8'hFA;
    run_poll(8'h05, 0, "a_sel");
    repeat (5) tick();
    // Active-low 1111_0110 means A + Start pressed.
    pad_word = 8'hF6;
    run_poll(8'h09, 0, "a_start");
    repeat (5) tick();
    pad_word = 8'h7E;
    run_poll(8'h81, 10, "dbl_start");
    repeat (5) tick();

    pad_mode = 2'd1;
    run_poll(8'h00, 0, "unplugged");
    repeat (5) tick();
    pad_mode = 2'd2;
    run_poll(8'hFF, 0, "all_low");
    pad_mode = 2'd0;
    repeat (5) tick();

    // Reset in the middle of a poll.
    clear_stats();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_latch", 32'(pad_latch), 32'd0);
    check("mid_rst_clk", 32'(pad_clk), 32'd0);
    check("mid_rst_keys", 32'(keycodes), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    repeat (100) tick();
    check("mid_rst_novalid", valid_cnt, 0);
    pad_word = 8'hFA;
    run_poll(8'h05, 0, "post_rst");
    repeat (5) tick();

    // Automatic polling, including a start coinciding with expiry.
    pad_word = 8'hEF;
    clear_stats();
    auto_en = 1'b1;
    wait_valid(300, n);
    check("auto_first", 32'(keycodes_valid), 32'd1);
    check("auto_keys", 32'(keycodes), 32'h10);
    repeat (130) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(300, n);
    check("auto_coinc_lat", n, 69);
    tick();
    wait_valid(300, n);
    check("auto_interval", n + 1, PP);
    tick();
    check("auto_valid_cnt", valid_cnt, 3);
    auto_en = 1'b0;
    repeat (450) tick();
    check("auto_off", valid_cnt, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
